// File: rtl/goldschmidt_ctrl.sv
// Sequencer for the Goldschmidt iteration datapath: accepts a request, steps ITERS N/D multiplies, returns the quotient.
// Optional GOLDSCHMIDT_DIVZERO_EN adds a div_by_zero flag and a short-circuit path for a zero divisor.
module goldschmidt_ctrl #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned ITERS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] numerator_in,
    input  logic [WIDTH-1:0] denominator_in,
    output logic [WIDTH-1:0] dp_numerator,
    output logic [WIDTH-1:0] dp_denominator,
    input  logic [WIDTH-1:0] dp_quotient,
    output logic             k_select,
    output logic             stage_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient_out
`ifdef GOLDSCHMIDT_DIVZERO_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int unsigned IT_W    = 4;
    localparam logic [IT_W-1:0] LAST_IT = IT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NSTEP = 2'd1,
        DSTEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [IT_W-1:0] it;

    // Outputs are registered alongside the state, so each transition also loads
    // the decode of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            it             <= '0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            quotient_out   <= '0;
            dp_numerator   <= '0;
            dp_denominator <= '0;
            k_select       <= 1'b0;
            stage_select   <= 1'b0;
`ifdef GOLDSCHMIDT_DIVZERO_EN
            div_by_zero    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dp_numerator   <= numerator_in;
                        dp_denominator <= denominator_in;
                        it             <= '0;
                        in_ready       <= 1'b0;
                        k_select       <= 1'b0;
                        stage_select   <= 1'b0;
`ifdef GOLDSCHMIDT_DIVZERO_EN
                        if (denominator_in == '0) begin
                            state        <= DONE;
                            out_valid    <= 1'b1;
                            quotient_out <= '1;
                            div_by_zero  <= 1'b1;
                        end else begin
                            state        <= NSTEP;
                            div_by_zero  <= 1'b0;
                        end
`else
                        state          <= NSTEP;
`endif
                    end
                end
                NSTEP: begin
                    if (it == LAST_IT) begin
                        quotient_out <= dp_quotient;
                        state        <= DONE;
                        out_valid    <= 1'b1;
                        k_select     <= 1'b0;
                        stage_select <= 1'b0;
                    end else begin
                        state        <= DSTEP;
                        k_select     <= (it != '0);
                        stage_select <= 1'b1;
                    end
                end
                DSTEP: begin
                    // Counter only advances here and NSTEP exits at LAST_IT, so no wrap.
                    it           <= it + IT_W'(1);
                    state        <= NSTEP;
                    k_select     <= 1'b1;
                    stage_select <= 1'b0;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    in_ready     <= 1'b1;
                    out_valid    <= 1'b0;
                    k_select     <= 1'b0;
                    stage_select <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Directed bench for goldschmidt_ctrl with a behavioural datapath stub (WIDTH=28, ITERS=4).
module tb_goldschmidt_ctrl;

    localparam int unsigned WIDTH = 28;
    localparam int unsigned ITERS = 4;
    localparam int unsigned BUSY  = 2 * ITERS - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] numerator_in;
    logic [WIDTH-1:0] denominator_in;
    logic [WIDTH-1:0] dp_numerator;
    logic [WIDTH-1:0] dp_denominator;
    logic [WIDTH-1:0] dp_quotient;
    logic             k_select;
    logic             stage_select;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient_out;
`ifdef GOLDSCHMIDT_DIVZERO_EN
    logic             div_by_zero;
`endif

    int checks = 0;
    int fails  = 0;

    logic [WIDTH-1:0] final_q = 28'h0ABCDEF;
    int               ncount;

    always #5 clk = ~clk;

    goldschmidt_ctrl #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .numerator_in   (numerator_in),
        .denominator_in (denominator_in),
        .dp_numerator   (dp_numerator),
        .dp_denominator (dp_denominator),
        .dp_quotient    (dp_quotient),
        .k_select       (k_select),
        .stage_select   (stage_select),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .quotient_out   (quotient_out)
`ifdef GOLDSCHMIDT_DIVZERO_EN
        ,
        .div_by_zero    (div_by_zero)
`endif
    );

    // Datapath stub: counts N steps of the current operation, drives final_q only in the last one.
    always @(posedge clk) begin
        if (reset || in_ready) ncount <= 0;
        else if (!out_valid && !stage_select) ncount <= ncount + 1;
    end
    assign dp_quotient = (!in_ready && !out_valid && !stage_select && ncount == int'(ITERS - 1))
                         ? final_q : 28'h5555555;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (quotient_out !== 28'h0) begin fails++; $display("FAIL reset_quotient got %h want 0", quotient_out); end
        checks++; if ({k_select, stage_select} !== 2'b00) begin fails++; $display("FAIL reset_k_stage got %b want 00", {k_select, stage_select}); end
        checks++; if ({dp_numerator, dp_denominator} !== 56'h0) begin fails++; $display("FAIL reset_dp_ops got %h/%h want 0/0", dp_numerator, dp_denominator); end
    endtask

    // Accept one request and walk the busy phase; the accepting edge counts as edge 1,
    // so out_valid must be high after edge 2*ITERS.
    task automatic run_op(input logic [WIDTH-1:0] num, input logic [WIDTH-1:0] den,
                          input logic [WIDTH-1:0] exp_q);
        logic [1:0] exp_ks [BUSY];
        int waited;
        exp_ks = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
        waited = 0;
        while (!in_ready && waited < 20) begin @(posedge clk); #1; waited++; end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL op_ready_timeout got %b want 1", in_ready); end
        numerator_in = num; denominator_in = den; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (dp_numerator !== num) begin fails++; $display("FAIL op_dp_num got %h want %h", dp_numerator, num); end
        checks++; if (dp_denominator !== den) begin fails++; $display("FAIL op_dp_den got %h want %h", dp_denominator, den); end
        for (int i = 0; i < int'(BUSY); i++) begin
            checks++;
            if ({out_valid, k_select, stage_select} !== {1'b0, exp_ks[i]}) begin
                fails++;
                $display("FAIL op_seq cycle %0d got v/k/s %b want %b", i, {out_valid, k_select, stage_select}, {1'b0, exp_ks[i]});
            end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL op_latency out_valid got %b want 1", out_valid); end
        checks++; if (quotient_out !== exp_q) begin fails++; $display("FAIL op_quotient got %h want %h", quotient_out, exp_q); end
        checks++; if ({in_ready, k_select, stage_select} !== 3'b000) begin fails++; $display("FAIL op_done_outputs got %b want 000", {in_ready, k_select, stage_select}); end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL drain_ready_valid got %b want 10", {in_ready, out_valid}); end
    endtask

    task automatic test_sequence();
        final_q = 28'h0ABCDEF;
        run_op(28'h4000000, 28'h6000000, 28'h0ABCDEF);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, quotient_out} !== {1'b1, 1'b0, 28'h0ABCDEF}) begin
                fails++;
                $display("FAIL hold cycle %0d got v=%b r=%b q=%h want v=1 r=0 q=0abcdef", i, out_valid, in_ready, quotient_out);
            end
        end
        finish_op();
    endtask

    task automatic test_busy_ignore();
        final_q = 28'h0777777;
        numerator_in = 28'h2000000; denominator_in = 28'h7000000; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < int'(BUSY); i++) begin
            numerator_in = 28'h1000000 + 28'(i);
            denominator_in = 28'h5000000 + 28'(i);
            checks++;
            if ({dp_numerator, dp_denominator} !== {28'h2000000, 28'h7000000}) begin
                fails++;
                $display("FAIL busy_relatch cycle %0d got %h/%h want 2000000/7000000", i, dp_numerator, dp_denominator);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if ({out_valid, quotient_out} !== {1'b1, 28'h0777777}) begin fails++; $display("FAIL busy_result got v=%b q=%h want v=1 q=0777777", out_valid, quotient_out); end
        finish_op();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL busy_single_result cycle %0d got %b want 10", i, {in_ready, out_valid}); end
        end
    endtask

    task automatic test_reset_mid();
        final_q = 28'h0123456;
        numerator_in = 28'h3000000; denominator_in = 28'h4000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, k_select, stage_select} !== 4'b1000) begin
            fails++;
            $display("FAIL midreset_ctrl got %b want 1000", {in_ready, out_valid, k_select, stage_select});
        end
        checks++;
        if ({quotient_out, dp_numerator, dp_denominator} !== 84'h0) begin
            fails++;
            $display("FAIL midreset_data got %h/%h/%h want 0/0/0", quotient_out, dp_numerator, dp_denominator);
        end
        run_op(28'h3000000, 28'h4000000, 28'h0123456);
        finish_op();
    endtask

    task automatic test_zero_divisor();
`ifdef GOLDSCHMIDT_DIVZERO_EN
        numerator_in = 28'h4000000; denominator_in = 28'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, div_by_zero, quotient_out} !== {1'b1, 1'b1, 28'hFFFFFFF}) begin
            fails++;
            $display("FAIL divzero_result got v=%b z=%b q=%h want v=1 z=1 q=fffffff", out_valid, div_by_zero, quotient_out);
        end
        finish_op();
        final_q = 28'h0222222;
        numerator_in = 28'h4000000; denominator_in = 28'h6000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL divzero_clear got %b want 0", div_by_zero); end
        repeat (BUSY) @(posedge clk);
        #1;
        checks++; if ({out_valid, quotient_out} !== {1'b1, 28'h0222222}) begin fails++; $display("FAIL divzero_next got v=%b q=%h want v=1 q=0222222", out_valid, quotient_out); end
        finish_op();
`else
        final_q = 28'h0333333;
        run_op(28'h4000000, 28'h0, 28'h0333333);
        finish_op();
`endif
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        numerator_in = '0; denominator_in = '0;
        test_reset();
        test_sequence();
        test_hold();
        test_busy_ignore();
        test_reset_mid();
        test_zero_divisor();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
